// File: rtl/song_player_pkg.sv
// Shared note codes, song constants and FSM encoding for the melody autoplayer.
package song_player_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd2;
  localparam logic [3:0] NOTE_E    = 4'd3;
  localparam logic [3:0] NOTE_F    = 4'd4;
  localparam logic [3:0] NOTE_G    = 4'd5;

  localparam int         SONG_LEN  = 15;
  localparam logic [3:0] LAST_IDX  = 4'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/song_rom.sv
// Ode to Joy phrase: combinational idx -> {note, len}; out-of-range reads silence.
module song_rom
  import song_player_pkg::*;
(
  input  logic [3:0] idx,
  output logic [3:0] note,
  output logic [2:0] len
);

  // melody lookup table
  always_comb begin
    note = NOTE_NONE;
    len  = 3'd0;
    case (idx)
      4'd0:    begin note = NOTE_E;  len = 3'd2; end
      4'd1:    begin note = NOTE_E;  len = 3'd2; end
      4'd2:    begin note = NOTE_F;  len = 3'd2; end
      4'd3:    begin note = NOTE_G;  len = 3'd2; end
      4'd4:    begin note = NOTE_G;  len = 3'd2; end
      4'd5:    begin note = NOTE_F;  len = 3'd2; end
      4'd6:    begin note = NOTE_E;  len = 3'd2; end
      4'd7:    begin note = NOTE_D;  len = 3'd2; end
      4'd8:    begin note = NOTE_C4; len = 3'd2; end
      4'd9:    begin note = NOTE_C4; len = 3'd2; end
      4'd10:   begin note = NOTE_D;  len = 3'd2; end
      4'd11:   begin note = NOTE_E;  len = 3'd2; end
      4'd12:   begin note = NOTE_E;  len = 3'd3; end
      4'd13:   begin note = NOTE_D;  len = 3'd1; end
      4'd14:   begin note = NOTE_D;  len = 3'd4; end
      default: begin note = NOTE_NONE; len = 3'd0; end
    endcase
  end

endmodule

// File: rtl/song_player.sv
// Melody autoplayer: steps through the song ROM, holding each note for
// len*UNIT_TICKS ticks followed by GAP_TICKS ticks of silence.
module song_player
  import song_player_pkg::*;
#(
  parameter int UNIT_TICKS = 4,
  parameter int GAP_TICKS  = 1,
  parameter int LOOP       = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] note,
  output logic       busy,
  output logic       done,
  output logic [3:0] idx
);

  localparam logic [11:0] UNIT_W   = 12'(UNIT_TICKS);
  localparam logic [11:0] GAP_LAST = 12'(GAP_TICKS - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [11:0] cnt_r;
  logic [11:0] cnt_nxt_s;
  logic [3:0]  idx_r;
  logic [3:0]  idx_nxt_s;
  logic [2:0]  len_r;
  logic [3:0]  note_r;
  logic [3:0]  note_nxt_s;
  logic        busy_r;
  logic        done_r;
  logic        done_nxt_s;
  logic [3:0]  rom_note_s;
  logic [2:0]  rom_len_s;
  logic [11:0] note_last_s;

  // The ROM is addressed with the next index so note/len register alongside the state.
  song_rom u_rom (
    .idx  (idx_nxt_s),
    .note (rom_note_s),
    .len  (rom_len_s)
  );

  assign note_last_s = 12'(len_r) * UNIT_W - 12'd1;

  // next-state, counter and index logic; stop overrides everything
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    done_nxt_s  = 1'b0;
    if (stop) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 12'd0;
      idx_nxt_s   = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_nxt_s = 12'd0;
          if (start) begin
            state_nxt_s = ST_NOTE;
            idx_nxt_s   = 4'd0;
          end else begin
            idx_nxt_s   = 4'd0;
          end
        end
        ST_NOTE: begin
          if (tick) begin
            if (cnt_r == note_last_s) begin
              state_nxt_s = ST_GAP;
              cnt_nxt_s   = 12'd0;
            end else begin
              cnt_nxt_s   = cnt_r + 12'd1;
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (cnt_r == GAP_LAST) begin
              cnt_nxt_s = 12'd0;
              if (idx_r < LAST_IDX) begin
                state_nxt_s = ST_NOTE;
                idx_nxt_s   = idx_r + 4'd1;
              end else if (LOOP != 0) begin
                state_nxt_s = ST_NOTE;
                idx_nxt_s   = 4'd0;
              end else begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 4'd0;
                done_nxt_s  = 1'b1;
              end
            end else begin
              cnt_nxt_s = cnt_r + 12'd1;
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 12'd0;
          idx_nxt_s   = 4'd0;
        end
      endcase
    end
    note_nxt_s = (state_nxt_s == ST_NOTE) ? rom_note_s : NOTE_NONE;
  end

  // state and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= 12'd0;
      idx_r   <= 4'd0;
      len_r   <= 3'd0;
      note_r  <= NOTE_NONE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      len_r   <= rom_len_s;
      note_r  <= note_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= done_nxt_s;
    end
  end

  assign note = note_r;
  assign busy = busy_r;
  assign done = done_r;
  assign idx  = idx_r;

endmodule
